// File: rtl/addsub_seq.sv
// Digit-serial adder/subtractor, DIGIT bits per clock, LSB digit first.
// Define ADDSUB_SEQ_SAT_EN to clamp the result to the signed limit on overflow.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("addsub_seq: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_cy;
  logic             r_sub;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH+DIGIT-1:0] w_acc_cat;
  logic [WIDTH+DIGIT-1:0] w_a_cat;
  logic [WIDTH+DIGIT-1:0] w_b_cat;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_res;
  logic             w_msb_cin;
  logic             w_ovf;
  logic             w_carry;

  assign w_accept = (r_state == S_IDLE) && r_in_ready && in_valid;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = w_run && (r_cnt == CW'(N - 1));

  // Operands shift right one digit per cycle; the low digit is always current.
  assign w_sum = {1'b0, r_a[DIGIT-1:0]}
               + {1'b0, r_b[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, r_cy};

  assign w_acc_cat = {w_sum[DIGIT-1:0], r_acc};
  assign w_acc_nxt = w_acc_cat[WIDTH+DIGIT-1:DIGIT];
  assign w_a_cat   = {{DIGIT{1'b0}}, r_a};
  assign w_b_cat   = {{DIGIT{1'b0}}, r_b};

  assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_sum[DIGIT-1];
  assign w_ovf     = w_msb_cin ^ w_sum[DIGIT];
  assign w_carry   = w_sum[DIGIT] ^ r_sub;

`ifdef ADDSUB_SEQ_SAT_EN
  always_comb begin
    w_res = w_acc_nxt;
    if (w_ovf) begin
      w_res = r_a[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_res = w_acc_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      r_state == S_IDLE: if (w_accept)  w_state_nxt = S_RUN;
      r_state == S_RUN:  if (w_last)    w_state_nxt = S_DONE;
      r_state == S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    unique case (1'b1)
      r_state == S_IDLE: w_in_ready_nxt = !w_accept;
      r_state == S_RUN:  w_out_valid_nxt = w_last;
      r_state == S_DONE: begin
        w_out_valid_nxt = !out_ready;
        w_in_ready_nxt  = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_cy    <= 1'b0;
      r_sub   <= 1'b0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= sub ? ~b : b;
      r_cy  <= sub;
      r_sub <= sub;
      r_cnt <= '0;
    end else if (w_run) begin
      r_a   <= w_a_cat[WIDTH+DIGIT-1:DIGIT];
      r_b   <= w_b_cat[WIDTH+DIGIT-1:DIGIT];
      r_acc <= w_acc_nxt;
      r_cy  <= w_sum[DIGIT];
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_res   <= w_res;
        r_carry <= w_carry;
        r_ovf   <= w_ovf;
        r_zero  <= (w_res == '0);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_res;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;

endmodule
